// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer capture/readout path.
package la_pkg;

  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 2048;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FIN
  } readout_state_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry register FIFO that absorbs the BRAM read latency ahead of the byte stream.
module skid_fifo2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset on purpose so the stream data reads 0 out of reset; state always uses <=.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/bram_readout.sv
// Streams a contiguous, wrapping window of the capture BRAM out as ready/valid bytes.
module bram_readout #(
  parameter int ADDR_W = la_pkg::ADDR_W,
  parameter int DATA_W = la_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  import la_pkg::*;

  readout_state_t    state;
  readout_state_t    state_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W:0]   issue_left;
  logic [ADDR_W:0]   beats_left;
  logic              inflight;
  logic [1:0]        fifo_count;
  logic [1:0]        pending;
  logic              handshake;
  logic              issue;
  logic              accept;

  assign handshake = out_valid && out_ready;
  assign pending   = fifo_count + {1'b0, inflight};
  // A beat leaving this cycle frees its slot, which keeps the stream at one byte per cycle.
  assign issue     = (state == READ) && (issue_left != '0) &&
                     ((pending - {1'b0, handshake}) < 2'd2);
  assign accept    = (state == IDLE) && start && (length != '0);

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (length == '0) ? FIN : READ;
      READ:    if (issue && (issue_left == (ADDR_W+1)'(1))) state_nxt = DRAIN;
      DRAIN:   if (handshake && (beats_left == (ADDR_W+1)'(1))) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      rd_addr    <= '0;
      last_addr  <= '0;
      issue_left <= '0;
      beats_left <= '0;
      inflight   <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (accept) begin
        rd_addr    <= start_addr;
        issue_left <= length;
        beats_left <= length;
      end else begin
        if (issue) begin
          rd_addr    <= rd_addr + 1'b1;
          last_addr  <= rd_addr;
          issue_left <= issue_left - 1'b1;
        end
        if (handshake) begin
          beats_left <= beats_left - 1'b1;
        end
      end
    end
  end

  // The read issued last cycle lands in mem_rdata at this edge and is pushed.
  skid_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (inflight),
    .push_data (mem_rdata),
    .pop       (handshake),
    .head      (out_data),
    .count     (fifo_count)
  );

  assign out_valid = (fifo_count != 2'd0);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign mem_en    = issue;
  assign mem_we    = 1'b0;
  assign mem_addr  = issue ? rd_addr : last_addr;

endmodule
